// File: rtl/fan_pkg.sv
// fan_pkg: shared types and constants for the fan control core.
// Provides the run-state enum, gear/pattern widths and the gear step helper.
package fan_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_TIMED,
        ST_HOLD
    } fan_state_e;

    localparam int GEAR_W   = 2;
    localparam int GEAR_MAX = 3;
    localparam int PAT_W    = 3;

    typedef logic [GEAR_W-1:0] gear_t;

    function automatic gear_t gear_step(gear_t cur, gear_t tgt);
        return (tgt > cur) ? cur + gear_t'(1) : cur - gear_t'(1);
    endfunction

endpackage

// File: rtl/fan_step_div.sv
// fan_step_div: programmable period counter with clear and strobe.
// Ports: clk, rst_n, en (count), clr (restart), period, strobe (last count).
module fan_step_div #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             strobe
);

    logic [CNT_W-1:0] cnt;

    // Left combinational so the parent registers it on the same
    // edge as the state it advances.
    assign strobe = en && !clr && (cnt == period - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || strobe)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/fan_ctrl_core.sv
// fan_ctrl_core: setpoint, ramped auto/manual gear, pattern strobe, timer.
// In: sw, temp/gear/tmr pulses, man_mode. Out: temp, gear, pattern, step_en, tmr_*.
module fan_ctrl_core
    import fan_pkg::*;
#(
    parameter int TEMP_W      = 6,
    parameter int TEMP_MIN    = 10,
    parameter int TEMP_MAX    = 40,
    parameter int TEMP_DEF    = 20,
    parameter int THR1        = 20,
    parameter int THR2        = 25,
    parameter int THR3        = 30,
    parameter int PAT_N       = 4,
    parameter int BASE_PERIOD = 1000,
    parameter int RAMP_CYC    = 50_000_000,
    parameter int TICK_DIV    = 50_000_000,
    parameter int TMR_W       = 6,
    parameter int TMR_STEP    = 10,
    parameter int TMR_MAX     = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw,
    input  logic              temp_up,
    input  logic              temp_dn,
    input  logic              man_mode,
    input  logic              gear_up,
    input  logic              gear_dn,
    input  logic              tmr_add,
    input  logic              tmr_clr,
    output logic [TEMP_W-1:0] temp,
    output logic [GEAR_W-1:0] gear,
    output logic [PAT_W-1:0]  pattern,
    output logic              step_en,
    output logic [TMR_W-1:0]  tmr_left,
    output logic              tmr_on,
    output logic              expired
);

    localparam int PDIV_W = $clog2(BASE_PERIOD + 1);
    localparam int SDIV_W = $clog2(TICK_DIV + 1);
    localparam int RAMP_W = $clog2(RAMP_CYC + 1);

    localparam logic [TEMP_W-1:0] T_MIN  = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] T_MAX  = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0] T_DEF  = TEMP_W'(TEMP_DEF);
    localparam logic [TEMP_W-1:0] T_THR1 = TEMP_W'(THR1);
    localparam logic [TEMP_W-1:0] T_THR2 = TEMP_W'(THR2);
    localparam logic [TEMP_W-1:0] T_THR3 = TEMP_W'(THR3);
    localparam logic [TMR_W-1:0]  L_STEP = TMR_W'(TMR_STEP);
    localparam logic [TMR_W-1:0]  L_MAX  = TMR_W'(TMR_MAX);
    localparam logic [PAT_W-1:0]  P_N    = PAT_W'(PAT_N);
    localparam logic [RAMP_W-1:0] R_CYC  = RAMP_W'(RAMP_CYC);
    localparam gear_t             G_MAX  = gear_t'(GEAR_MAX);

    fan_state_e        state, state_nxt;
    logic [TMR_W-1:0]  left_nxt;
    logic [TMR_W:0]    tmr_sum;
    logic              exp_nxt;
    logic              man_d;
    gear_t             man_tgt, auto_tgt, tgt;
    logic [RAMP_W-1:0] ramp_cnt;
    logic              gear_mv;
    logic [PDIV_W-1:0] period;
    logic              pat_en, pat_clr, pat_hit;
    logic              sec_en, sec_clr, sec_tick;

    // Setpoint
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            temp <= T_DEF;
        else if (!sw)
            temp <= T_DEF;
        else if (state != ST_OFF) begin
            if (temp_up && !temp_dn && temp < T_MAX)
                temp <= temp + TEMP_W'(1);
            else if (temp_dn && !temp_up && temp > T_MIN)
                temp <= temp - TEMP_W'(1);
        end
    end

    // Target gear
    always_comb begin
        auto_tgt = '0;
        if (temp >= T_THR3)
            auto_tgt = gear_t'(3);
        else if (temp >= T_THR2)
            auto_tgt = gear_t'(2);
        else if (temp >= T_THR1)
            auto_tgt = gear_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            man_d   <= 1'b0;
            man_tgt <= '0;
        end else begin
            man_d <= man_mode;
            if (man_mode && !man_d)
                man_tgt <= auto_tgt;
            else if (man_mode) begin
                if (gear_up && !gear_dn && man_tgt != G_MAX)
                    man_tgt <= man_tgt + gear_t'(1);
                else if (gear_dn && !gear_up && man_tgt != '0)
                    man_tgt <= man_tgt - gear_t'(1);
            end
        end
    end

    // On the man_mode rising cycle man_tgt is still stale, so keep
    // following the auto target until it has been loaded.
    always_comb begin
        tgt = auto_tgt;
        if (state == ST_OFF || state == ST_HOLD)
            tgt = '0;
        else if (man_mode && man_d)
            tgt = man_tgt;
    end

    // Ramp: idle counter allows an immediate first step
    assign gear_mv = sw && (gear != tgt)
                  && (ramp_cnt == '0 || ramp_cnt == R_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gear     <= '0;
            ramp_cnt <= '0;
        end else if (!sw) begin
            gear     <= '0;
            ramp_cnt <= '0;
        end else if (gear == tgt)
            ramp_cnt <= '0;
        else if (gear_mv) begin
            gear     <= gear_step(gear, tgt);
            ramp_cnt <= RAMP_W'(1);
        end else
            ramp_cnt <= ramp_cnt + RAMP_W'(1);
    end

    // Pattern step
    always_comb begin
        period = PDIV_W'(BASE_PERIOD);
        unique case (gear)
            2'd2:    period = PDIV_W'(BASE_PERIOD >> 1);
            2'd3:    period = PDIV_W'(BASE_PERIOD >> 2);
            default: period = PDIV_W'(BASE_PERIOD);
        endcase
    end

    assign pat_en  = (gear != '0)
                  && (state == ST_RUN || state == ST_TIMED);
    assign pat_clr = gear_mv || !sw;

    fan_step_div #(.CNT_W(PDIV_W)) u_pat_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pat_en),
        .clr    (pat_clr),
        .period (period),
        .strobe (pat_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= '0;
            step_en <= 1'b0;
        end else if (!sw) begin
            pattern <= '0;
            step_en <= 1'b0;
        end else begin
            step_en <= pat_hit;
            if (pat_hit)
                pattern <= (pattern == '0 || pattern >= P_N)
                         ? PAT_W'(1) : pattern + PAT_W'(1);
        end
    end

    // Timer seconds
    assign sec_en  = (state == ST_TIMED);
    assign sec_clr = (state != ST_TIMED) || tmr_clr;

    fan_step_div #(.CNT_W(SDIV_W)) u_sec_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (sec_en),
        .clr    (sec_clr),
        .period (SDIV_W'(TICK_DIV)),
        .strobe (sec_tick)
    );

    assign tmr_sum = {1'b0, tmr_left} + {1'b0, L_STEP};

    always_comb begin
        state_nxt = state;
        left_nxt  = tmr_left;
        exp_nxt   = 1'b0;
        if (!sw) begin
            state_nxt = ST_OFF;
            left_nxt  = '0;
        end else begin
            unique case (state)
                ST_OFF: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (tmr_add && !tmr_clr) begin
                        state_nxt = ST_TIMED;
                        left_nxt  = L_STEP;
                    end
                end
                ST_TIMED: begin
                    if (tmr_clr) begin
                        state_nxt = ST_RUN;
                        left_nxt  = '0;
                    end else if (tmr_add)
                        left_nxt = (tmr_sum > {1'b0, L_MAX})
                                 ? L_MAX : tmr_sum[TMR_W-1:0];
                    else if (sec_tick) begin
                        left_nxt = tmr_left - TMR_W'(1);
                        if (tmr_left == TMR_W'(1)) begin
                            state_nxt = ST_HOLD;
                            exp_nxt   = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_clr) begin
                        state_nxt = ST_RUN;
                        left_nxt  = '0;
                    end else if (tmr_add) begin
                        state_nxt = ST_TIMED;
                        left_nxt  = L_STEP;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            tmr_left <= '0;
            tmr_on   <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr_left <= left_nxt;
            tmr_on   <= (state_nxt == ST_TIMED);
            expired  <= exp_nxt;
        end
    end

endmodule

// File: tb/tb_fan_ctrl_core.sv
// tb_fan_ctrl_core: randomized and directed bench for fan_ctrl_core.
// Compares every cycle against a behavioural model of the fan rules.
module tb_fan_ctrl_core;

    localparam int BASE  = 16;
    localparam int RAMP  = 4;
    localparam int TICK  = 10;
    localparam int STEP  = 3;
    localparam int TMAX  = 60;
    localparam int T_DEF = 20;
    localparam int T_MIN = 10;
    localparam int T_MAX = 40;
    localparam int THR1  = 20;
    localparam int THR2  = 25;
    localparam int THR3  = 30;
    localparam int PATN  = 4;

    localparam int S_OFF = 0, S_RUN = 1, S_TIMED = 2, S_HOLD = 3;

    localparam logic [19:0] RST_VEC = {6'd20, 14'd0};

    logic clk = 0, rst_n = 0, sw = 0;
    logic temp_up = 0, temp_dn = 0, man_mode = 0;
    logic gear_up = 0, gear_dn = 0, tmr_add = 0, tmr_clr = 0;
    logic [5:0]  temp;
    logic [1:0]  gear;
    logic [2:0]  pattern;
    logic        step_en;
    logic [5:0]  tmr_left;
    logic        tmr_on, expired;
    logic [19:0] obs;

    assign obs = {temp, gear, pattern, step_en, tmr_left, tmr_on, expired};

    int total = 0, bad = 0;

    int m_st, m_temp, m_gear, m_pat, m_step, m_left, m_on, m_exp;
    int m_man_prev, m_mtgt, m_idle, m_last, m_phase, m_sec, cyc_n;

    always #5 clk = ~clk;

    fan_ctrl_core #(
        .BASE_PERIOD (BASE),
        .RAMP_CYC    (RAMP),
        .TICK_DIV    (TICK),
        .TMR_STEP    (STEP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .temp_up  (temp_up),
        .temp_dn  (temp_dn),
        .man_mode (man_mode),
        .gear_up  (gear_up),
        .gear_dn  (gear_dn),
        .tmr_add  (tmr_add),
        .tmr_clr  (tmr_clr),
        .temp     (temp),
        .gear     (gear),
        .pattern  (pattern),
        .step_en  (step_en),
        .tmr_left (tmr_left),
        .tmr_on   (tmr_on),
        .expired  (expired)
    );

    function automatic logic [19:0] exp_vec();
        return {6'(m_temp), 2'(m_gear), 3'(m_pat), 1'(m_step),
                6'(m_left), 1'(m_on), 1'(m_exp)};
    endfunction

    task automatic model_reset();
        m_st = S_OFF; m_temp = T_DEF; m_gear = 0; m_pat = 0;
        m_step = 0; m_left = 0; m_on = 0; m_exp = 0;
        m_man_prev = 0; m_mtgt = 0; m_idle = 1; m_last = 0;
        m_phase = 0; m_sec = 0;
    endtask

    // One clock edge of the fan rules, using the pre-edge model state.
    task automatic model_edge();
        int auto_t, tgt, ngear, nst, per;
        bit moved, tk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc_n++;
        auto_t = (m_temp >= THR3) ? 3 : (m_temp >= THR2) ? 2 :
                 (m_temp >= THR1) ? 1 : 0;
        if (m_st == S_OFF || m_st == S_HOLD) tgt = 0;
        else if (man_mode && m_man_prev) tgt = m_mtgt;
        else tgt = auto_t;
        if (man_mode && !m_man_prev) m_mtgt = auto_t;
        else if (man_mode) begin
            if (gear_up && !gear_dn && m_mtgt < 3) m_mtgt++;
            else if (gear_dn && !gear_up && m_mtgt > 0) m_mtgt--;
        end
        m_man_prev = man_mode;
        moved = 0;
        ngear = m_gear;
        if (!sw) begin
            ngear = 0; m_idle = 1;
        end else if (m_gear == tgt) m_idle = 1;
        else if (m_idle || cyc_n - m_last >= RAMP) begin
            ngear = m_gear + ((tgt > m_gear) ? 1 : -1);
            m_idle = 0; m_last = cyc_n; moved = 1;
        end
        m_step = 0;
        if (!sw) begin
            m_pat = 0; m_phase = 0;
        end else if (moved) m_phase = 0;
        else if (m_gear > 0 && (m_st == S_RUN || m_st == S_TIMED)) begin
            per = BASE >> (m_gear - 1);
            m_phase++;
            if (m_phase == per) begin
                m_phase = 0; m_step = 1; m_pat = m_pat % PATN + 1;
            end
        end
        tk = 0;
        if (m_st == S_TIMED && !tmr_clr) begin
            m_sec++;
            if (m_sec == TICK) begin tk = 1; m_sec = 0; end
        end else m_sec = 0;
        m_exp = 0;
        nst = m_st;
        if (!sw) begin
            nst = S_OFF; m_left = 0;
        end else if (m_st == S_OFF) nst = S_RUN;
        else if (m_st == S_RUN) begin
            if (tmr_add && !tmr_clr) begin nst = S_TIMED; m_left = STEP; end
        end else if (m_st == S_TIMED) begin
            if (tmr_clr) begin nst = S_RUN; m_left = 0; end
            else if (tmr_add) m_left = (m_left + STEP > TMAX) ? TMAX : m_left + STEP;
            else if (tk) begin
                m_left--;
                if (m_left == 0) begin nst = S_HOLD; m_exp = 1; end
            end
        end else begin
            if (tmr_clr) begin nst = S_RUN; m_left = 0; end
            else if (tmr_add) begin nst = S_TIMED; m_left = STEP; end
        end
        if (!sw) m_temp = T_DEF;
        else if (m_st != S_OFF) begin
            if (temp_up && !temp_dn && m_temp < T_MAX) m_temp++;
            else if (temp_dn && !temp_up && m_temp > T_MIN) m_temp--;
        end
        m_gear = ngear;
        m_st = nst;
        m_on = (nst == S_TIMED);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        cyc_n = 0;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL reset_vals got=%h want=%h", obs, RST_VEC);
        end
        rst_n = 1;
        tick();
        total++;
        if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL reset_off got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_power_on();
        int steps[$];
        int pats[$];
        int want[5] = '{1, 2, 3, 4, 1};
        sw = 1;
        repeat (100) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL power_on cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
            if (step_en) begin
                steps.push_back(cyc_n);
                pats.push_back(int'(pattern));
            end
        end
        total++;
        if (gear !== 2'd1 || temp !== 6'd20) begin
            bad++;
            $display("FAIL power_on_gear gear=%0d temp=%0d want 1/20", gear, temp);
        end
        total++;
        if (pats.size() < 5) begin
            bad++;
            $display("FAIL step_count got=%0d want>=5", pats.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (pats[i] != want[i]) begin
                    bad++;
                    $display("FAIL pat_seq i=%0d got=%0d want=%0d", i, pats[i], want[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                total++;
                if (steps[i] - steps[i-1] != BASE) begin
                    bad++;
                    $display("FAIL step_gap1 got=%0d want=%0d", steps[i] - steps[i-1], BASE);
                end
            end
        end
    endtask

    task automatic test_setpoint();
        int last_chg = -1000;
        int prev_g;
        int s0 = -1, s1 = -1;
        bit gap_ok = 1;
        prev_g = int'(gear);
        for (int i = 0; i < 55; i++) begin
            temp_up = (i < 50) && (i % 2 == 0);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL setpoint cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
            if (int'(gear) != prev_g) begin
                if (cyc_n - last_chg < RAMP) gap_ok = 0;
                last_chg = cyc_n;
                prev_g = int'(gear);
            end
        end
        temp_up = 0;
        total++;
        if (temp !== 6'd40 || gear !== 2'd3) begin
            bad++;
            $display("FAIL temp_sat temp=%0d gear=%0d want 40/3", temp, gear);
        end
        total++;
        if (!gap_ok) begin
            bad++;
            $display("FAIL ramp_gap got=short want>=%0d", RAMP);
        end
        for (int i = 0; i < 20 && s1 < 0; i++) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL gear3_run got=%h want=%h", obs, exp_vec());
            end
            if (step_en) begin
                if (s0 < 0) s0 = cyc_n;
                else s1 = cyc_n;
            end
        end
        total++;
        if (s1 < 0 || s1 - s0 != BASE >> 2) begin
            bad++;
            $display("FAIL step_gap3 got=%0d want=%0d", s1 - s0, BASE >> 2);
        end
    endtask

    task automatic test_simul();
        int p0, nstep = 0;
        temp_up = 1; temp_dn = 1;
        tick();
        temp_up = 0; temp_dn = 0;
        tick();
        total++;
        if (temp !== 6'd40 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL both_pulses got=%0d want=40", temp);
        end
        for (int i = 0; i < 94; i++) begin
            temp_dn = (i < 64) && (i % 2 == 0);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL temp_down cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
        end
        temp_dn = 0;
        total++;
        if (temp !== 6'd10 || gear !== 2'd0) begin
            bad++;
            $display("FAIL temp_floor temp=%0d gear=%0d want 10/0", temp, gear);
        end
        p0 = int'(pattern);
        repeat (40) begin
            tick();
            if (step_en) nstep++;
        end
        total++;
        if (int'(pattern) != p0 || nstep != 0) begin
            bad++;
            $display("FAIL pat_frozen got=%0d/%0d want=%0d/0", pattern, nstep, p0);
        end
    endtask

    task automatic test_manual();
        for (int i = 0; i < 54; i++) begin
            temp_up = (i < 34) && (i % 2 == 0);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL man_prep cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
        end
        temp_up = 0;
        total++;
        if (temp !== 6'd27 || gear !== 2'd2) begin
            bad++;
            $display("FAIL auto_g2 temp=%0d gear=%0d want 27/2", temp, gear);
        end
        man_mode = 1;
        for (int i = 0; i < 46; i++) begin
            gear_up = (i >= 10) && (i < 16) && (i % 2 == 0);
            gear_dn = (i == 36);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL manual cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
            if (i == 9 && gear !== 2'd2) begin
                total++; bad++;
                $display("FAIL man_load got=%0d want=2", gear);
            end
            if (i == 35 && gear !== 2'd3) begin
                total++; bad++;
                $display("FAIL man_up_sat got=%0d want=3", gear);
            end
        end
        gear_up = 0; gear_dn = 0;
        total++;
        if (gear !== 2'd2) begin
            bad++;
            $display("FAIL man_dn got=%0d want=2", gear);
        end
    endtask

    task automatic test_timer();
        int nexp = 0;
        man_mode = 0;
        for (int i = 0; i < 9; i++) begin
            tmr_add = (i == 5) || (i == 7);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL tmr_add cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
        end
        tmr_add = 0;
        total++;
        if (tmr_left !== 6'd6 || tmr_on !== 1'b1) begin
            bad++;
            $display("FAIL tmr_six got=%0d/%0d want 6/1", tmr_left, tmr_on);
        end
        repeat (80) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL countdown cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
            if (expired) nexp++;
        end
        total++;
        if (nexp != 1 || tmr_on !== 1'b0 || tmr_left !== 6'd0 || gear !== 2'd0) begin
            bad++;
            $display("FAIL expire n=%0d on=%0d left=%0d gear=%0d want 1/0/0/0",
                     nexp, tmr_on, tmr_left, gear);
        end
        tmr_clr = 1;
        tick();
        tmr_clr = 0;
        repeat (20) begin
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL resume cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
        end
        total++;
        if (gear !== 2'd2 || tmr_on !== 1'b0) begin
            bad++;
            $display("FAIL resume_gear gear=%0d on=%0d want 2/0", gear, tmr_on);
        end
    endtask

    task automatic test_power_off();
        for (int i = 0; i < 46; i++) begin
            temp_up = (i < 16) && (i % 2 == 0);
            tick();
        end
        temp_up = 0;
        total++;
        if (gear !== 2'd3 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL pre_off gear=%0d want=3", gear);
        end
        sw = 0;
        tick();
        total++;
        if (gear !== 2'd0 || pattern !== 3'd0 || temp !== 6'd20 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL power_off got=%0d/%0d/%0d want 0/0/20", gear, pattern, temp);
        end
        sw = 1;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid();
        tmr_add = 1;
        tick();
        tmr_add = 0;
        repeat (4) tick();
        total++;
        if (tmr_on !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_timed got=%0d want=1", tmr_on);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL async_rst got=%h want=%h", obs, RST_VEC);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        total++;
        if (step_en !== 1'b0 || expired !== 1'b0 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL rst_release got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            temp_up  = ($urandom_range(0, 5) == 0);
            temp_dn  = ($urandom_range(0, 6) == 0);
            gear_up  = ($urandom_range(0, 7) == 0);
            gear_dn  = ($urandom_range(0, 7) == 0);
            tmr_add  = ($urandom_range(0, 39) == 0);
            tmr_clr  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) man_mode = ~man_mode;
            if (sw ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 4) == 0))
                sw = ~sw;
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc_n, obs, exp_vec());
            end
        end
        {temp_up, temp_dn, gear_up, gear_dn, tmr_add, tmr_clr} = '0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_setpoint();
        test_simul();
        test_manual();
        test_timer();
        test_power_off();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fan_ctrl_core.md
# fan_ctrl_core

Parametrised fan control core, the successor to the fixed fan top-level controller. It takes debounced button pulses and turns them into:
- a saturating temperature setpoint;
- an automatic or manual gear, with rate-limited (ramped) gear changes;
- a pattern-step enable for the dot-matrix animation, replacing the derived divided clock;
- a countdown shutdown timer.

It sits between the debounce block and the display blocks (dot matrix, segment LED, LCD). Everything runs in one clock domain.

## Interface
- TEMP_W, 6: temperature register width.
- TEMP_MIN / TEMP_MAX / TEMP_DEF, 10 / 40 / 20: setpoint floor, ceiling and power-off default.
- THR1 / THR2 / THR3, 20 / 25 / 30: auto-mode gear thresholds.
- PAT_N, 4: number of animation patterns (1..PAT_N).
- BASE_PERIOD, 1000: clk cycles per pattern step at gear 1; gear g uses BASE_PERIOD >> (g-1).
- RAMP_CYC, 50_000_000: minimum clk cycles between successive one-step gear changes.
- TICK_DIV, 50_000_000: clk cycles per timer second.
- TMR_W / TMR_STEP / TMR_MAX, 6 / 10 / 60: timer width, increment per add, saturation value (seconds).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  1  fan power switch (level).
- temp_up / temp_dn  in  1  one-cycle setpoint pulses.
- man_mode  in  1  1 = manual gear, 0 = auto from temperature.
- gear_up / gear_dn  in  1  one-cycle manual gear pulses (ignored in auto).
- tmr_add / tmr_clr  in  1  one-cycle timer pulses.
- temp  out  TEMP_W  current setpoint.
- gear  out  2  actual gear 0..3 (0 = stopped).
- pattern  out  3  animation index (0 = blank).
- step_en  out  1  one-cycle strobe on each pattern advance.
- tmr_left  out  TMR_W  remaining seconds.
- tmr_on  out  1  high in TIMED state.
- expired  out  1  one-cycle pulse when the timer reaches 0.

## Operation
- **States:**
  - OFF: sw low.
  - RUN: on, no timer.
  - TIMED: countdown active.
  - HOLD: timer expired; gear forced to 0 and pattern frozen.
- **State transitions:**
  - sw low from any state → OFF.
  - OFF with sw high → RUN.
  - RUN with tmr_add → TIMED, tmr_left = TMR_STEP.
  - TIMED with tmr_add → tmr_left + TMR_STEP, saturating at TMR_MAX.
  - TIMED when tmr_left reaches 0 → HOLD, with an expired pulse.
  - HOLD with tmr_add → TIMED, tmr_left = TMR_STEP.
  - TIMED or HOLD with tmr_clr → RUN, tmr_left = 0.
  - tmr_add and tmr_clr in the same cycle: tmr_clr wins.
- **Setpoint:**
  - Active in RUN, TIMED and HOLD.
  - temp_up increments, saturating at TEMP_MAX; temp_dn decrements, saturating at TEMP_MIN.
  - Both pulses in the same cycle: no change.
  - In OFF, temp is held at TEMP_DEF.
- **Target gear:**
  - Auto mode: temp < THR1 → 0; THR1..THR2-1 → 1; THR2..THR3-1 → 2; ≥ THR3 → 3.
  - Manual mode: a target register stepped by gear_up/gear_dn, saturating at 3 and 0. It is loaded with the current auto target on the rising edge of man_mode.
  - HOLD and OFF force the target to 0.
- **Ramp:**
  - While gear ≠ target, gear moves one step toward target.
  - The first step happens immediately if the ramp counter is idle; after that, one step per RAMP_CYC cycles.
  - The ramp counter resets when gear equals target.
  - OFF sets gear to 0 immediately, with no ramp.
- **Pattern:**
  - The divider counts only while gear > 0. At count = period-1 it pulses step_en and advances pattern 1→2→…→PAT_N→1.
  - The divider count clears on every gear change.
  - While gear = 0 in RUN/TIMED/HOLD, pattern is frozen.
  - In OFF, pattern = 0. The first step after leaving OFF goes to 1.
- **Timer:** the second prescaler runs only in TIMED; each tick decrements tmr_left.

## Timing
- **Reset values:** state OFF, temp = TEMP_DEF, gear = 0, pattern = 0, step_en = 0, tmr_left = 0, tmr_on = 0, expired = 0, all counters 0.
- **Output latency:**
  - All outputs are registered.
  - temp changes 1 cycle after its pulse.
  - A gear step can start 1 cycle after the target changes.
- **Pattern timing:** step_en and pattern update on the same edge; step spacing is exactly BASE_PERIOD >> (gear-1) cycles.
- **Expiry timing:** expired is asserted on the same edge that tmr_left becomes 0 and state becomes HOLD.
- **Reset mid-operation:** asynchronous return to reset values; no pulse outputs are asserted on release.

## Structure
- **Package fan_pkg:**
  - state enum (OFF, RUN, TIMED, HOLD);
  - gear width;
  - GEAR_MAX = 3;
  - pattern width.
- **Sub-module fan_step_div:** a programmable period counter with a clear input and a one-cycle strobe output. It is used twice: for the pattern step and for the timer second tick.

## Test plan
Sim parameters: BASE_PERIOD = 16, RAMP_CYC = 4, TICK_DIV = 10, TMR_STEP = 3.
- **Reset and power-on:** reset, then sw = 1 → temp = 20, gear ramps 0→1; step_en every 16 cycles; pattern 1,2,3,4,1.
- **Setpoint saturation and ramp:** 25 temp_up pulses → temp saturates at 40. Gear goes 1→2→3, with steps ≥ 4 cycles apart. Step spacing drops to 8, then 4 cycles.
- **Simultaneous setpoint pulses:** temp_up and temp_dn in the same cycle → temp unchanged. temp_dn taken down to 10 → saturates; gear reaches 0; pattern frozen.
- **Manual mode:** man_mode = 1 at auto gear 2 → target stays 2. Three gear_up pulses → gear 3 only. gear_dn → 2.
- **Timer:** tmr_add twice → tmr_left = 6. After 60 cycles, expired pulses once, state is HOLD, gear ramps to 0. tmr_clr → RUN, and the auto gear resumes.
- **Power-off and reset mid-operation:** sw = 0 at gear 3 → gear = 0, pattern = 0, temp = 20 on the next edge. rst_n pulled low during TIMED → all outputs at reset values asynchronously.
